// File: rtl/chip8_timers.sv
// CHIP-8 delay and sound timers: bus-readable/writable 8-bit counters decremented
// by a free-running 60 Hz prescaler, with a square-wave buzzer while sound is nonzero.
module chip8_timers #(
    parameter int TICK_DIV = 416667,
    parameter int TONE_DIV = 28409
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_delay,
    input  logic       cs_sound,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       rd_valid,
    output logic       tick60,
    output logic       sound_active,
    output logic       buzzer
);

    localparam int PRE_W  = $clog2(TICK_DIV);
    localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);

    logic [PRE_W-1:0]  r_pre;
    logic [TONE_W-1:0] r_tone;
    logic [7:0]        r_delay;
    logic [7:0]        r_sound;
    logic [7:0]        r_rdata;
    logic              r_rd_valid;
    logic              r_tick;
    logic              r_buzzer;

    logic       w_wr_delay;
    logic       w_wr_sound;
    logic       w_rd_hit;
    logic       w_tone_restart;
    logic [7:0] w_delay_nxt;
    logic [7:0] w_sound_nxt;

    // Read handshake: a read strobe qualified by either select is accepted
    // unconditionally; rd_valid pulses for one cycle on the following cycle with
    // rdata holding the pre-edge timer value, and rdata holds otherwise.
    assign w_wr_delay     = wr_en & cs_delay;
    assign w_wr_sound     = wr_en & cs_sound;
    assign w_rd_hit       = rd_en & (cs_delay | cs_sound);
    assign w_tone_restart = w_wr_sound & (wdata != 8'd0);

    always_comb begin
        w_delay_nxt = r_delay;
        w_sound_nxt = r_sound;
        if (w_wr_delay) begin
            w_delay_nxt = wdata;
        end else if (r_tick && (r_delay != 8'd0)) begin
            w_delay_nxt = r_delay - 8'd1;
        end
        if (w_wr_sound) begin
            w_sound_nxt = wdata;
        end else if (r_tick && (r_sound != 8'd0)) begin
            w_sound_nxt = r_sound - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_pre == PRE_LAST);
            r_pre  <= (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_delay <= 8'd0;
            r_sound <= 8'd0;
        end else begin
            r_delay <= w_delay_nxt;
            r_sound <= w_sound_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata    <= 8'd0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_hit;
            if (w_rd_hit) begin
                r_rdata <= cs_delay ? r_delay : r_sound;
            end
        end
    end

    // A fresh nonzero sound write restarts the tone at phase 0 even if already sounding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tone   <= '0;
            r_buzzer <= 1'b0;
        end else if (w_tone_restart || (r_sound == 8'd0)) begin
            r_tone   <= '0;
            r_buzzer <= 1'b0;
        end else if (r_tone == TONE_LAST) begin
            r_tone   <= '0;
            r_buzzer <= ~r_buzzer;
        end else begin
            r_tone <= r_tone + 1'b1;
        end
    end

    assign rdata        = r_rdata;
    assign rd_valid     = r_rd_valid;
    assign tick60       = r_tick;
    assign sound_active = (r_sound != 8'd0);
    assign buzzer       = r_buzzer;

endmodule

// File: doc/chip8_timers.md
Name: chip8_timers

Overview:
Delay-timer and sound-timer peripheral for the CHIP-8 system bus. It sits directly downstream of the address decoder and is enabled by two of its chip-select lines: cs_delay (decoder output bit 2, address 0x0003) and cs_sound (decoder output bit 3, address 0x0004). Both timers are 8-bit registers that the CPU can read and write, and a free-running 60 Hz prescaler decrements them. While the sound timer is nonzero, the block drives a square-wave buzzer output.

Parameters:
TICK_DIV, 416667, number of clk cycles per 60 Hz tick (25 MHz / 60). Must be >= 2.
TONE_DIV, 28409, number of clk cycles per buzzer half-period (about 440 Hz at 25 MHz). Must be >= 1.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
cs_delay  input  1  chip select for the delay timer, from the address decoder.
cs_sound  input  1  chip select for the sound timer, from the address decoder.
wr_en  input  1  bus write strobe, qualified by a chip select.
rd_en  input  1  bus read strobe, qualified by a chip select.
wdata  input  8  write data.
rdata  output  8  registered read data.
rd_valid  output  1  one-cycle pulse marking rdata valid.
tick60  output  1  one-cycle pulse at each prescaler wrap.
sound_active  output  1  high while the sound timer is nonzero.
buzzer  output  1  square-wave tone output.

Behaviour:
- Reset (rst_n low, asynchronous): delay, sound, prescaler, tone counter, rdata, rd_valid, tick60 and buzzer all clear to 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick60 is registered: it is high for exactly the one cycle after the counter reaches TICK_DIV-1.
  - Free-running; bus accesses never reset or stall it.
- Decrement: in a cycle where tick60 is high, each timer that is nonzero decrements by 1. A timer at 0 stays at 0; it never wraps to 0xFF.
- Write:
  - wr_en and cs_delay together load delay from wdata on the next edge.
  - wr_en and cs_sound together load sound from wdata on the next edge.
  - If both selects are high, both timers load.
  - If a write coincides with tick60 on the same timer, the write wins and the loaded value is not decremented that cycle.
- Read:
  - rd_en with cs_delay or cs_sound captures the timer's current value (its value before this edge's update) into rdata. rd_valid goes high one cycle later, so latency is 1.
  - If both selects are high, delay takes priority.
  - rdata holds its last value when rd_valid is low.
  - rd_en with no select: no rd_valid pulse and rdata is unchanged.
  - Read and write in the same cycle: rdata returns the old value and the write takes effect.
- Strobes: wr_en or rd_en with neither select high is ignored.
- sound_active is combinational: (sound != 0).
- Buzzer:
  - While sound_active is high, the tone counter counts 0..TONE_DIV-1, and buzzer toggles on each wrap.
  - When sound is 0, the tone counter and buzzer are forced to 0 on the next edge.
  - A new nonzero write restarts the tone from phase 0, with buzzer low.
- Reset asserted mid-countdown: everything clears immediately; after release, counting restarts from prescaler 0.

Test Plan:
1. Reset release with TICK_DIV=4 → tick60 pulses every 4 cycles; all outputs 0 before the first write.
2. Write 0x03 to delay, then read at each tick → reads return 3, 2, 1, 0, 0. rd_valid lags rd_en by exactly 1 cycle and the timer never wraps to 0xFF.
3. Write 0x05 to sound in the exact cycle tick60 is high → sound reads 0x05, not 0x04. The next tick yields 0x04.
4. Sound=0x02 with TONE_DIV=2 → buzzer toggles every 2 cycles while sound_active=1. After 2 ticks, sound_active=0 and buzzer returns to 0 within 1 cycle.
5. Assert cs_delay and cs_sound together with wr_en, wdata=0xAA → both timers become 0xAA. A following rd_en with both selects returns delay.
6. Assert rst_n low mid-countdown (delay=0x10) → delay, rdata and buzzer are 0 immediately, without waiting for a clock edge. After release, the first tick arrives TICK_DIV cycles later.
